// File: rtl/iiitb_bcd_sa_if.sv
// Handshake/operand bundle for the serial BCD adder/subtractor.
// Master drives a request; slave returns ready, result and done.
interface iiitb_bcd_sa_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  sub;
  logic                  carry_in;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  carry;
  logic                  done;
  logic                  invalid;

  modport master (
    output start, sub, carry_in, a, b,
    input  ready, sum, carry, done, invalid
  );

  modport slave (
    input  start, sub, carry_in, a, b,
    output ready, sum, carry, done, invalid
  );
endinterface

// File: rtl/iiitb_bcd_sa.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock,
// LSB first; results publish only on entry to DONE.
module iiitb_bcd_sa #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic                carry_in,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                carry,
  output logic                done,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d;
  logic          sub_q, sub_d;
  logic          inv_q, inv_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          invalid_q, invalid_d;

  logic [3:0]    a_dig;
  logic [3:0]    b_raw;
  logic [3:0]    b_dig;
  logic [4:0]    t;
  logic          gt;
  logic [3:0]    dig;
  logic          bad;
  logic          last;
  logic [W+3:0]  cat;

  // Operand registers shift right so the live digit is always [3:0].
  always_comb begin
    a_dig = a_q[3:0];
    b_raw = b_q[3:0];
    b_dig = sub_q ? (4'd9 - b_raw) : b_raw;
    t     = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, c_q};
    gt    = (t > 5'd9);
    dig   = gt ? 4'(t - 5'd10) : t[3:0];
    bad   = (a_dig > 4'd9) || (b_raw > 4'd9);
    last  = (cnt_q == CW'(DIGITS - 1));
    cat   = {dig, acc_q};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    c_d       = c_q;
    sub_d     = sub_q;
    inv_d     = inv_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    invalid_d = invalid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = carry_in;
          sub_d   = sub;
          cnt_d   = '0;
          inv_d   = 1'b0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        acc_d = cat[W+3:4];
        c_d   = gt;
        inv_d = inv_q | bad;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          sum_d     = cat[W+3:4];
          carry_d   = gt;
          invalid_d = inv_q | bad;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      sub_q     <= 1'b0;
      inv_q     <= 1'b0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      c_q       <= c_d;
      sub_q     <= sub_d;
      inv_q     <= inv_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      invalid_q <= invalid_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = (state_q == DONE);
  assign sum     = sum_q;
  assign carry   = carry_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_iiitb_bcd_sa.sv
// Directed bench for the serial BCD adder/subtractor at
// DIGITS = 4, 1 and 8 with hand-computed expectations.
module tb_iiitb_bcd_sa;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  iiitb_bcd_sa_if #(.DIGITS(4)) if4 ();
  iiitb_bcd_sa_if #(.DIGITS(1)) if1 ();
  iiitb_bcd_sa_if #(.DIGITS(8)) if8 ();

  iiitb_bcd_sa #(.DIGITS(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (if4.start),
    .sub      (if4.sub),
    .carry_in (if4.carry_in),
    .a        (if4.a),
    .b        (if4.b),
    .ready    (if4.ready),
    .sum      (if4.sum),
    .carry    (if4.carry),
    .done     (if4.done),
    .invalid  (if4.invalid)
  );

  iiitb_bcd_sa #(.DIGITS(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (if1.start),
    .sub      (if1.sub),
    .carry_in (if1.carry_in),
    .a        (if1.a),
    .b        (if1.b),
    .ready    (if1.ready),
    .sum      (if1.sum),
    .carry    (if1.carry),
    .done     (if1.done),
    .invalid  (if1.invalid)
  );

  iiitb_bcd_sa #(.DIGITS(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (if8.start),
    .sub      (if8.sub),
    .carry_in (if8.carry_in),
    .a        (if8.a),
    .b        (if8.b),
    .ready    (if8.ready),
    .sum      (if8.sum),
    .carry    (if8.carry),
    .done     (if8.done),
    .invalid  (if8.invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic [63:0] a,
                       input logic [63:0] b, input logic s,
                       input logic ci, input logic st);
    case (w)
      1: begin
        if1.a = a[3:0]; if1.b = b[3:0];
        if1.sub = s; if1.carry_in = ci; if1.start = st;
      end
      8: begin
        if8.a = a[31:0]; if8.b = b[31:0];
        if8.sub = s; if8.carry_in = ci; if8.start = st;
      end
      default: begin
        if4.a = a[15:0]; if4.b = b[15:0];
        if4.sub = s; if4.carry_in = ci; if4.start = st;
      end
    endcase
  endtask

  task automatic set_start(input int w, input logic st);
    case (w)
      1:       if1.start = st;
      8:       if8.start = st;
      default: if4.start = st;
    endcase
  endtask

  function automatic logic rdy(input int w);
    case (w)
      1:       return if1.ready;
      8:       return if8.ready;
      default: return if4.ready;
    endcase
  endfunction

  function automatic logic dn(input int w);
    case (w)
      1:       return if1.done;
      8:       return if8.done;
      default: return if4.done;
    endcase
  endfunction

  task automatic get(input int w, output logic [63:0] s,
                     output logic c, output logic inv);
    case (w)
      1:       begin s = 64'(if1.sum); c = if1.carry; inv = if1.invalid; end
      8:       begin s = 64'(if8.sum); c = if8.carry; inv = if8.invalid; end
      default: begin s = 64'(if4.sum); c = if4.carry; inv = if4.invalid; end
    endcase
  endtask

  // Called #1 after an edge with the DUT idle; returns edges from
  // accept to done and the number of ready-low samples.
  task automatic op(input int w, input logic [63:0] a,
                    input logic [63:0] b, input logic s,
                    input logic ci, input bit glitch,
                    output int lat, output int rlow);
    drive(w, a, b, s, ci, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    lat  = -1;
    rlow = 0;
    if (!rdy(w)) rlow++;
    for (int n = 1; n <= 40; n++) begin
      if (glitch && n == 1)
        drive(w, 64'h1111_1111, 64'h1111_1111, 1'b1, 1'b0, 1'b1);
      if (glitch && n == 2)
        set_start(w, 1'b0);
      @(posedge clk); #1;
      if (!rdy(w)) rlow++;
      if (dn(w)) begin
        lat = n;
        @(posedge clk); #1;
        if (!rdy(w)) rlow++;
        break;
      end
    end
  endtask

  logic [63:0] s_o;
  logic        c_o;
  logic        i_o;
  int          lat;
  int          rlow;
  int          d_seen;
  int          d_t0;
  int          d_t1;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive(4, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(8, 0, 0, 0, 0, 0);
    #2;
    check("rst_ready", 64'(if4.ready), 1);
    get(4, s_o, c_o, i_o);
    check("rst_sum", s_o, 0);
    check("rst_carry", 64'(c_o), 0);
    check("rst_done", 64'(if4.done), 0);
    check("rst_inv", 64'(i_o), 0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    get(4, s_o, c_o, i_o);
    check("idle_sum", s_o, 0);
    check("idle_ready", 64'(if4.ready), 1);
    check("idle_done", 64'(if4.done), 0);

    op(4, 64'h0006, 64'h0009, 0, 0, 0, lat, rlow);
    get(4, s_o, c_o, i_o);
    check("add6_9_sum", s_o, 64'h0015);
    check("add6_9_carry", 64'(c_o), 0);
    check("add6_9_lat", 64'(lat), 4);
    check("add6_9_rlow", 64'(rlow), 5);

    op(4, 64'h9999, 64'h9999, 0, 1, 0, lat, rlow);
    get(4, s_o, c_o, i_o);
    check("add99_sum", s_o, 64'h9999);
    check("add99_carry", 64'(c_o), 1);

    op(4, 64'h9999, 64'h0001, 0, 0, 0, lat, rlow);
    get(4, s_o, c_o, i_o);
    check("ripple_sum", s_o, 64'h0000);
    check("ripple_carry", 64'(c_o), 1);

    op(4, 64'h0100, 64'h0001, 1, 1, 0, lat, rlow);
    get(4, s_o, c_o, i_o);
    check("sub100_1_sum", s_o, 64'h0099);
    check("sub100_1_carry", 64'(c_o), 1);

    op(4, 64'h0001, 64'h0002, 1, 1, 0, lat, rlow);
    get(4, s_o, c_o, i_o);
    check("sub1_2_sum", s_o, 64'h9999);
    check("sub1_2_carry", 64'(c_o), 0);

    op(4, 64'h00A0, 64'h0001, 0, 0, 0, lat, rlow);
    get(4, s_o, c_o, i_o);
    check("inv_flag", 64'(i_o), 1);
    check("inv_lat", 64'(lat), 4);

    op(4, 64'h0012, 64'h0034, 0, 0, 0, lat, rlow);
    get(4, s_o, c_o, i_o);
    check("inv_clear", 64'(i_o), 0);
    check("inv_clear_sum", s_o, 64'h0046);

    op(4, 64'h2222, 64'h3333, 0, 0, 1, lat, rlow);
    get(4, s_o, c_o, i_o);
    check("midstart_sum", s_o, 64'h5555);
    check("midstart_carry", 64'(c_o), 0);
    check("midstart_lat", 64'(lat), 4);

    // Start held high: dones must come every 6 edges.
    drive(4, 64'h0001, 64'h0002, 0, 0, 1);
    d_seen = 0;
    d_t0   = -100;
    d_t1   = -100;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (if4.done) begin
        if (d_seen == 0) d_t0 = n;
        if (d_seen == 1) d_t1 = n;
        d_seen++;
      end
    end
    set_start(4, 1'b0);
    check("held_period", 64'(d_t1 - d_t0), 6);
    check("held_first", 64'(d_t0), 5);
    get(4, s_o, c_o, i_o);
    check("held_sum", s_o, 64'h0003);
    repeat (8) @(posedge clk);
    #1;

    // Reset at the second RUN cycle aborts with no done.
    drive(4, 64'h4444, 64'h4444, 0, 0, 1);
    @(posedge clk); #1;
    set_start(4, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    get(4, s_o, c_o, i_o);
    check("abort_ready", 64'(if4.ready), 1);
    check("abort_sum", s_o, 0);
    check("abort_carry", 64'(c_o), 0);
    d_seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (if4.done) d_seen++;
    end
    check("abort_nodone", 64'(d_seen), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(4, 64'h1234, 64'h4321, 0, 0, 0, lat, rlow);
    get(4, s_o, c_o, i_o);
    check("post_rst_sum", s_o, 64'h5555);
    check("post_rst_carry", 64'(c_o), 0);
    check("post_rst_lat", 64'(lat), 4);

    op(1, 64'h6, 64'h9, 0, 0, 0, lat, rlow);
    get(1, s_o, c_o, i_o);
    check("d1_sum", s_o, 64'h5);
    check("d1_carry", 64'(c_o), 1);
    check("d1_lat", 64'(lat), 1);
    check("d1_rlow", 64'(rlow), 2);
    op(1, 64'h9, 64'h9, 0, 1, 0, lat, rlow);
    get(1, s_o, c_o, i_o);
    check("d1_99_sum", s_o, 64'h9);
    check("d1_99_carry", 64'(c_o), 1);

    op(8, 64'h6, 64'h9, 0, 0, 0, lat, rlow);
    get(8, s_o, c_o, i_o);
    check("d8_sum", s_o, 64'h15);
    check("d8_carry", 64'(c_o), 0);
    check("d8_lat", 64'(lat), 8);
    check("d8_rlow", 64'(rlow), 9);
    op(8, 64'h9999_9999, 64'h9999_9999, 0, 1, 0, lat, rlow);
    get(8, s_o, c_o, i_o);
    check("d8_99_sum", s_o, 64'h9999_9999);
    check("d8_99_carry", 64'(c_o), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
